// File: rtl/ne16_column_reduce_pipe.sv
// NE16 BinConv column reduction: sums or selects COLUMN_SIZE signed block partials
// through a one- or two-level registered adder tree with valid/ready flow control.
module ne16_column_reduce_pipe #(
    parameter int  COLUMN_SIZE = 9,
    parameter int  IN_W        = 22,
    parameter int  GROUP_SIZE  = 3,
    parameter int  PIPE_STAGES = 2,
    parameter int  STRB_W      = (IN_W + $clog2(COLUMN_SIZE)) / 8,
    localparam int OUT_W       = IN_W + $clog2(COLUMN_SIZE),
    localparam int SEL_W       = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        enable_i,
    input  logic [COLUMN_SIZE-1:0]      block_en_i,
    input  logic                        mode_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic [OUT_W-1:0]            padding_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [COLUMN_SIZE*IN_W-1:0] in_data_i,
    input  logic [STRB_W-1:0]           in_strb_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [OUT_W-1:0]            out_data_o,
    output logic [STRB_W-1:0]           out_strb_o,
    output logic                        busy_o
);
    localparam int NUM_GROUPS = (COLUMN_SIZE + GROUP_SIZE - 1) / GROUP_SIZE;

    logic [COLUMN_SIZE-1:0][OUT_W-1:0] blk_ext;
    logic [NUM_GROUPS-1:0][OUT_W-1:0]  grp_sum;
    logic [OUT_W-1:0]                  sel_val;
    logic                              in_fire;

    // Two's-complement sums wrap identically signed or unsigned, so only the
    // extension needs to be signed; OUT_W is wide enough that no sum overflows.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        blk_ext = '0;
        grp_sum = '0;
        sel_val = '0;
        for (int k = 0; k < COLUMN_SIZE; k++) begin
            if (block_en_i[k]) begin
                blk_ext[k] = OUT_W'(signed'(in_data_i[k*IN_W +: IN_W]));
            end
            grp_sum[k / GROUP_SIZE] = grp_sum[k / GROUP_SIZE] + blk_ext[k];
            if (int'(sel_i) == k) begin
                sel_val = blk_ext[k];
            end
        end
    end

    if (PIPE_STAGES == 1) begin : g_one_stage
        logic                v_q, v_d;
        logic [OUT_W-1:0]    data_q, data_d, tree_sum;
        logic [STRB_W-1:0]   strb_q, strb_d;

        assign in_ready_o = ~v_q | out_ready_i;
        assign in_fire    = in_valid_i & in_ready_o & ~clear_i;

        always_comb begin
            tree_sum = '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                tree_sum = tree_sum + grp_sum[g];
            end
            v_d    = in_fire | (v_q & ~out_ready_i);
            data_d = data_q;
            strb_d = strb_q;
            if (in_fire) begin
                data_d = enable_i ? (mode_i ? sel_val : tree_sum) : padding_i;
                strb_d = in_strb_i;
            end
            if (clear_i) begin
                v_d    = 1'b0;
                data_d = '0;
                strb_d = '0;
            end
        end

        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q    <= 1'b0;
                data_q <= '0;
                strb_q <= '0;
            end else begin
                v_q    <= v_d;
                data_q <= data_d;
                strb_q <= strb_d;
            end
        end

        assign out_valid_o = v_q;
        assign out_data_o  = data_q;
        assign out_strb_o  = strb_q;
        assign busy_o      = v_q;
    end else begin : g_two_stage
        logic                             v1_q, v1_d, v2_q, v2_d;
        logic [NUM_GROUPS-1:0][OUT_W-1:0] grp1_q, grp1_d;
        logic                             en1_q, en1_d, mode1_q, mode1_d;
        logic [OUT_W-1:0]                 sel1_q, sel1_d, pad1_q, pad1_d;
        logic [OUT_W-1:0]                 data2_q, data2_d, total1;
        logic [STRB_W-1:0]                strb1_q, strb1_d, strb2_q, strb2_d;
        logic                             s2_free, s1_adv;

        assign s2_free    = ~v2_q | out_ready_i;
        assign s1_adv     = v1_q & s2_free;
        assign in_ready_o = ~v1_q | s2_free;
        assign in_fire    = in_valid_i & in_ready_o & ~clear_i;

        always_comb begin
            total1 = '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                total1 = total1 + grp1_q[g];
            end

            v1_d    = in_fire | (v1_q & ~s2_free);
            grp1_d  = grp1_q;
            en1_d   = en1_q;
            mode1_d = mode1_q;
            sel1_d  = sel1_q;
            pad1_d  = pad1_q;
            strb1_d = strb1_q;
            if (in_fire) begin
                grp1_d  = grp_sum;
                en1_d   = enable_i;
                mode1_d = mode_i;
                sel1_d  = sel_val;
                pad1_d  = padding_i;
                strb1_d = in_strb_i;
            end

            v2_d    = s1_adv | (v2_q & ~out_ready_i);
            data2_d = data2_q;
            strb2_d = strb2_q;
            if (s1_adv) begin
                data2_d = en1_q ? (mode1_q ? sel1_q : total1) : pad1_q;
                strb2_d = strb1_q;
            end

            if (clear_i) begin
                v1_d    = 1'b0;
                grp1_d  = '0;
                en1_d   = 1'b0;
                mode1_d = 1'b0;
                sel1_d  = '0;
                pad1_d  = '0;
                strb1_d = '0;
                v2_d    = 1'b0;
                data2_d = '0;
                strb2_d = '0;
            end
        end

        // NOTE: the group-sum array is packed, so a single '0 clears every entry on reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v1_q    <= 1'b0;
                grp1_q  <= '0;
                en1_q   <= 1'b0;
                mode1_q <= 1'b0;
                sel1_q  <= '0;
                pad1_q  <= '0;
                strb1_q <= '0;
                v2_q    <= 1'b0;
                data2_q <= '0;
                strb2_q <= '0;
            end else begin
                v1_q    <= v1_d;
                grp1_q  <= grp1_d;
                en1_q   <= en1_d;
                mode1_q <= mode1_d;
                sel1_q  <= sel1_d;
                pad1_q  <= pad1_d;
                strb1_q <= strb1_d;
                v2_q    <= v2_d;
                data2_q <= data2_d;
                strb2_q <= strb2_d;
            end
        end

        assign out_valid_o = v2_q;
        assign out_data_o  = data2_q;
        assign out_strb_o  = strb2_q;
        assign busy_o      = v1_q | v2_q;
    end

endmodule
